// File: rtl/mux_4_1_rr.sv
// Four-lane round-robin collector onto one registered output lane.
// Each word is tagged with its source channel on dout_sel.
module mux_4_1_rr #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  input  logic              vld0,
  input  logic              vld1,
  input  logic              vld2,
  input  logic              vld3,
  output logic              rdy0,
  output logic              rdy1,
  output logic              rdy2,
  output logic              rdy3,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        dout_sel,
  output logic              dout_vld,
  input  logic              dout_rdy
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [1:0]        sel_q, sel_d;
  logic              vld_q, vld_d;
  logic [1:0]        ptr_q, ptr_d;

  logic [3:0]        vld_v;
  logic [3:0]        rdy_v;
  logic [1:0]        gnt;
  logic              gnt_ok;
  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] din_g;

  assign vld_v = {vld3, vld2, vld1, vld0};

  always_comb begin
    logic [1:0] idx;
    gnt    = ptr_q;
    gnt_ok = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_ok && vld_v[idx]) begin
        gnt_ok = 1'b1;
        gnt    = idx;
      end
    end
  end

  // rst_n gates ready so no producer sees a transfer while held in reset
  assign can_load = rst_n & (~vld_q | dout_rdy);
  assign load     = can_load & gnt_ok;

  always_comb begin
    rdy_v = '0;
    if (load) rdy_v[gnt] = 1'b1;
  end

  assign {rdy3, rdy2, rdy1, rdy0} = rdy_v;

  always_comb begin
    din_g = din0;
    unique case (gnt)
      2'd0: din_g = din0;
      2'd1: din_g = din1;
      2'd2: din_g = din2;
      2'd3: din_g = din3;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (load) begin
      dout_d = din_g;
      sel_d  = gnt;
      vld_d  = 1'b1;
      ptr_d  = gnt + 2'd1;
    end else if (vld_q && dout_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      dout_q <= dout_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign dout     = dout_q;
  assign dout_sel = sel_q;
  assign dout_vld = vld_q;

endmodule
